// File: rtl/daco_edge_pkg.sv
// Shared types and constants for the edge-store read path.
package daco_edge_pkg;
  localparam int EDGE_ADDR_W = 10;
  localparam int EDGE_DATA_W = 36;
  localparam int EDGE_RD_LAT = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_e;

  typedef struct packed {
    logic                   last;
    logic [EDGE_DATA_W-1:0] data;
  } edge_beat_t;
endpackage

// File: rtl/edge_stream_fifo.sv
// Small register FIFO buffering edge beats between the RAM read pipe and the stream.
module edge_stream_fifo
  import daco_edge_pkg::*;
#(
  parameter int W     = EDGE_DATA_W + 1,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [PW:0]   occupancy
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          pop_en;

  assign pop_en = pop && (cnt_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_en) rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign empty     = (cnt_q == '0);
  assign occupancy = cnt_q;

endmodule

// File: rtl/edge_reader.sv
// Streaming read engine: walks an edge-RAM address range and emits the words as a
// valid/ready stream, hiding the RAM read latency behind a credit-limited FIFO.
module edge_reader
  import daco_edge_pkg::*;
#(
  parameter int ADDR_W     = EDGE_ADDR_W,
  parameter int DATA_W     = EDGE_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rdaddr,
  input  logic [DATA_W-1:0] q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              vld_p0_q, vld_p0_d, last_p0_q, last_p0_d;
  logic              vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic [DATA_W:0]   fifo_head;
  logic              fifo_empty;
  logic [OCC_W-1:0]  fifo_occ;
  logic [OCC_W:0]    credit_sum;
  logic              credit_ok;
  logic              pop;

  // Credit counts FIFO entries plus reads still in the RAM pipe, all registered,
  // so the issue decision never depends combinationally on out_ready.
  assign credit_sum = {1'b0, fifo_occ} + (OCC_W+1)'(vld_p0_q) + (OCC_W+1)'(vld_p1_q);
  assign credit_ok  = credit_sum < (OCC_W+1)'(FIFO_DEPTH);
  assign pop        = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rdaddr_d    = rdaddr_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    vld_p0_d    = 1'b0;
    last_p0_d   = 1'b0;
    vld_p1_d    = vld_p0_q;
    last_p1_d   = last_p0_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (count == '0) begin
            remaining_d = '0;
            state_d     = DRAIN;
          end else begin
            // First read issues on the accept edge to hide one cycle of fill.
            rdaddr_d    = base_addr;
            addr_d      = base_addr + ADDR_W'(1);
            remaining_d = count - (ADDR_W+1)'(1);
            vld_p0_d    = 1'b1;
            last_p0_d   = (count == (ADDR_W+1)'(1));
            state_d     = (count == (ADDR_W+1)'(1)) ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if ((remaining_q != '0) && credit_ok) begin
          rdaddr_d    = addr_q;
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          vld_p0_d    = 1'b1;
          last_p0_d   = (remaining_q == (ADDR_W+1)'(1));
          if (remaining_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The empty/idle-pipe term only fires for zero-length commands.
        if ((pop && out_last) || (fifo_empty && !vld_p0_q && !vld_p1_q)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rdaddr_q    <= '0;
      remaining_q <= '0;
      vld_p0_q    <= 1'b0;
      last_p0_q   <= 1'b0;
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rdaddr_q    <= rdaddr_d;
      remaining_q <= remaining_d;
      vld_p0_q    <= vld_p0_d;
      last_p0_q   <= last_p0_d;
      vld_p1_q    <= vld_p1_d;
      last_p1_q   <= last_p1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Stage p1: RAM data is valid now and is pushed at the end of this cycle.
  edge_stream_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_p1_q),
    .push_data ({last_p1_q, q}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[DATA_W-1:0];
  assign out_last  = fifo_head[DATA_W];
  assign rdaddr    = rdaddr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_edge_reader.sv
// Randomized self-checking bench for edge_reader with a registered-read RAM model
// and a queue-based reference of the expected beat stream.
module tb_edge_reader;
  localparam int AW = 10;
  localparam int DW = 36;

  logic          clk, rst_n, start, busy, done, out_valid, out_ready, out_last;
  logic [AW-1:0] base_addr, rdaddr;
  logic [AW:0]   count;
  logic [DW-1:0] q, out_data;

  logic [DW-1:0] ram [1024];
  int total = 0;
  int bad   = 0;

  logic [DW:0]   beats[$];
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] trace[$];
  int first_valid, done_cnt, done_idx, stall_err, max_occ, valid_cnt;
  bit timeout, busy0;

  edge_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .rdaddr(rdaddr), .q(q), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) q <= ram[rdaddr];

  task automatic build_ref(input int b, input int c);
    exp_q.delete();
    for (int k = 0; k < c; k++)
      exp_q.push_back({(k == c - 1) ? 1'b1 : 1'b0, ram[(b + k) % 1024]});
  endtask

  task automatic do_start(input int b, input int c);
    start = 1'b1; base_addr = AW'(b); count = (AW+1)'(c);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Steps the clock, driving out_ready per mode and recording what the stream does.
  task automatic collect(input int max_cyc, input int mode, input int inject_at,
                         input int stop_beats, input bit b2b, input int b2_base, input int b2_cnt);
    logic [DW:0] prev_beat;
    bit prev_stall, saw_done;
    beats.delete(); trace.delete();
    first_valid = -1; done_cnt = 0; done_idx = -1; stall_err = 0; max_occ = 0;
    valid_cnt = 0; timeout = 1'b1; busy0 = busy; prev_stall = 1'b0; prev_beat = '0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      start = 1'b0;
      if (cyc == inject_at) begin start = 1'b1; base_addr = 10'd100; count = 11'd5; end
      trace.push_back(rdaddr);
      if (prev_stall && ({out_last, out_data} !== prev_beat)) stall_err++;
      if (out_valid) begin valid_cnt++; if (first_valid < 0) first_valid = cyc; end
      if (int'(dut.u_fifo.occupancy) > max_occ) max_occ = int'(dut.u_fifo.occupancy);
      if (out_valid && out_ready) beats.push_back({out_last, out_data});
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_last, out_data};
      saw_done   = (done === 1'b1);
      if (saw_done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = cyc;
        if (b2b) begin start = 1'b1; base_addr = AW'(b2_base); count = (AW+1)'(b2_cnt); end
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (stop_beats > 0 && beats.size() == stop_beats) begin timeout = 1'b0; break; end
      if (saw_done && b2b) begin timeout = 1'b0; break; end
      if (done_idx >= 0 && cyc >= done_idx + 2) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    total++;
    if ({busy, done, out_valid, out_last} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl got %b want 0000", {busy, done, out_valid, out_last});
    end
    total++;
    if (rdaddr !== '0) begin bad++; $display("FAIL reset_rdaddr got %0d want 0", rdaddr); end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL reset_data got %h want 0", out_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    build_ref(5, 4);
    do_start(5, 4);
    collect(200, 0, -1, 0, 1'b0, 0, 0);
    total++;
    if (timeout) begin bad++; $display("FAIL basic_timeout got 1 want 0"); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (trace[i] !== AW'(5 + i)) begin
        bad++; $display("FAIL basic_rdaddr[%0d] got %0d want %0d", i, trace[i], 5 + i);
      end
    end
    total++;
    if (beats.size() != 4) begin bad++; $display("FAIL basic_nbeats got %0d want 4", beats.size()); end
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      total++;
      if (beats[i] !== {(i == 3) ? 1'b1 : 1'b0, DW'(16 + 3 * i)}) begin
        bad++; $display("FAIL basic_beat[%0d] got %h want %h", i, beats[i], {(i == 3), DW'(16 + 3 * i)});
      end
    end
    total++;
    if (first_valid != 2) begin bad++; $display("FAIL basic_latency got %0d want 2", first_valid); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_backpressure;
    build_ref(0, 16);
    do_start(0, 16);
    collect(400, 1, -1, 0, 1'b0, 0, 0);
    total++;
    if (beats.size() != 16) begin bad++; $display("FAIL bp_nbeats got %0d want 16", beats.size()); end
    for (int i = 0; i < 16 && i < beats.size(); i++) begin
      total++;
      if (beats[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_beat[%0d] got %h want %h", i, beats[i], exp_q[i]);
      end
    end
    total++;
    if (stall_err != 0) begin bad++; $display("FAIL bp_stable got %0d changes want 0", stall_err); end
    total++;
    if (max_occ > 4) begin bad++; $display("FAIL bp_occupancy got %0d want <=4", max_occ); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL bp_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap_zero;
    build_ref(1022, 4);
    do_start(1022, 4);
    collect(200, 0, -1, 0, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (trace[i] !== AW'((1022 + i) % 1024)) begin
        bad++; $display("FAIL wrap_rdaddr[%0d] got %0d want %0d", i, trace[i], (1022 + i) % 1024);
      end
    end
    total++;
    if (beats.size() != 4) begin bad++; $display("FAIL wrap_nbeats got %0d want 4", beats.size()); end
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      total++;
      if (beats[i] !== exp_q[i]) begin
        bad++; $display("FAIL wrap_beat[%0d] got %h want %h", i, beats[i], exp_q[i]);
      end
    end
    do_start(7, 0);
    collect(50, 0, -1, 0, 1'b0, 0, 0);
    total++;
    if (first_valid != -1) begin bad++; $display("FAIL zero_valid got cycle %0d want none", first_valid); end
    total++;
    if (busy0 !== 1'b1) begin bad++; $display("FAIL zero_busy got %b want 1", busy0); end
    total++;
    if (done_idx != 1) begin bad++; $display("FAIL zero_done_idx got %0d want 1", done_idx); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL zero_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_busy;
    build_ref(200, 8);
    do_start(200, 8);
    collect(300, 1, 3, 0, 1'b0, 0, 0);
    total++;
    if (beats.size() != 8) begin bad++; $display("FAIL busy_nbeats got %0d want 8", beats.size()); end
    for (int i = 0; i < 8 && i < beats.size(); i++) begin
      total++;
      if (beats[i] !== exp_q[i]) begin
        bad++; $display("FAIL busy_beat[%0d] got %h want %h", i, beats[i], exp_q[i]);
      end
    end
    total++;
    if ({busy, out_valid} !== 2'b00 || done_cnt != 1) begin
      bad++; $display("FAIL busy_after got busy=%b valid=%b done=%0d want 0 0 1", busy, out_valid, done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    build_ref(10, 3);
    do_start(10, 3);
    collect(200, 0, -1, 0, 1'b1, 300, 32);
    total++;
    if (beats.size() != 3 || beats[2] !== exp_q[2]) begin
      bad++; $display("FAIL b2b_first got %0d beats want 3", beats.size());
    end
    build_ref(300, 32);
    collect(300, 0, -1, 0, 1'b0, 0, 0);
    total++;
    if (beats.size() != 32) begin bad++; $display("FAIL b2b_nbeats got %0d want 32", beats.size()); end
    for (int i = 0; i < 32 && i < beats.size(); i++) begin
      total++;
      if (beats[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_beat[%0d] got %h want %h", i, beats[i], exp_q[i]);
      end
    end
    total++;
    if (first_valid != 2 || valid_cnt != 32) begin
      bad++; $display("FAIL b2b_throughput got first=%0d cycles=%0d want 2 32", first_valid, valid_cnt);
    end
    total++;
    if (done_idx != 34) begin bad++; $display("FAIL b2b_done_idx got %0d want 34", done_idx); end
  endtask

  task automatic test_reset_mid;
    do_start(0, 10);
    collect(200, 0, -1, 3, 1'b0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, busy, done} !== 3'b0 || rdaddr !== '0) begin
      bad++; $display("FAIL rstmid_clear got v=%b b=%b d=%b a=%0d want 0", out_valid, busy, done, rdaddr);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    build_ref(50, 2);
    do_start(50, 2);
    collect(100, 0, -1, 0, 1'b0, 0, 0);
    total++;
    if (beats.size() != 2 || done_cnt != 1) begin
      bad++; $display("FAIL rstmid_after got %0d beats %0d done want 2 1", beats.size(), done_cnt);
    end
    for (int i = 0; i < 2 && i < beats.size(); i++) begin
      total++;
      if (beats[i] !== exp_q[i]) begin
        bad++; $display("FAIL rstmid_beat[%0d] got %h want %h", i, beats[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random;
    int b, c;
    for (int i = 0; i < 1024; i++) ram[i] = {4'($urandom_range(0, 15)), 32'($urandom)};
    for (int n = 0; n < 6; n++) begin
      b = $urandom_range(0, 1023);
      c = $urandom_range(1, 40);
      build_ref(b, c);
      do_start(b, c);
      collect(1000, 2, -1, 0, 1'b0, 0, 0);
      total++;
      if (beats.size() != c || done_cnt != 1) begin
        bad++; $display("FAIL rand%0d_count got %0d beats %0d done want %0d 1", n, beats.size(), done_cnt, c);
      end
      for (int i = 0; i < c && i < beats.size(); i++) begin
        total++;
        if (beats[i] !== exp_q[i]) begin
          bad++; $display("FAIL rand%0d_beat[%0d] got %h want %h", n, i, beats[i], exp_q[i]);
        end
      end
      total++;
      if (stall_err != 0 || max_occ > 4) begin
        bad++; $display("FAIL rand%0d_stall got %0d changes occ %0d want 0 <=4", n, stall_err, max_occ);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) ram[i] = DW'(i * 3 + 1);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_zero();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
